// File: rtl/riscv_core_rob_pkg.sv
// ROB geometry and entry layout, shared between the
// bookkeeping control block and the datapath data array.
package riscv_core_rob_pkg;

    localparam int ROB_SLOTS = 16;
    localparam int ROB_LOG_S = 4;
    localparam int REG_AW    = 5;

    typedef struct packed {
        logic              valid;
        logic              pending;
        logic              wen;
        logic [REG_AW-1:0] waddr;
    } rob_entry_t;

endpackage

// File: rtl/riscv_core_rob_youngest_match.sv
// Picks the youngest set bit of a slot match vector, where
// age is measured backwards from the tail (tail-1 is youngest).
module riscv_core_rob_youngest_match
    import riscv_core_rob_pkg::*;
#(
    parameter int SLOTS = ROB_SLOTS,
    parameter int LOG_S = ROB_LOG_S
) (
    input  logic [SLOTS-1:0] match,
    input  logic [LOG_S-1:0] tail,
    output logic             found,
    output logic [LOG_S-1:0] slot
);

    logic [LOG_S-1:0] idx;

    // Oldest first, so the last hit (tail-1) overrides earlier ones.
    always_comb begin
        found = 1'b0;
        slot  = '0;
        idx   = '0;
        for (int k = SLOTS; k >= 1; k--) begin
            idx = tail - LOG_S'(k);
            if (match[idx]) begin
                found = 1'b1;
                slot  = idx;
            end
        end
    end

endmodule

// File: rtl/riscv_core_rob_ctrl.sv
// Reorder-buffer bookkeeping: in-order allocate and retire,
// out-of-order fill, and youngest-producer bypass queries.
module riscv_core_rob_ctrl
    import riscv_core_rob_pkg::*;
#(
    parameter int SLOTS = ROB_SLOTS,
    parameter int LOG_S = ROB_LOG_S
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rob_alloc_req_val,
    output logic              rob_alloc_req_rdy,
    input  logic              rob_alloc_req_wen,
    input  logic [REG_AW-1:0] rob_alloc_req_waddr,
    output logic [LOG_S-1:0]  rob_alloc_resp_slot,
    input  logic              rob_fill_val,
    input  logic [LOG_S-1:0]  rob_fill_slot,
    output logic              rob_commit_val,
    output logic              rob_commit_wen,
    output logic [LOG_S-1:0]  rob_commit_slot,
    output logic [REG_AW-1:0] rob_commit_waddr,
    input  logic [REG_AW-1:0] rob_src0_reg,
    output logic              rob_src0_pend,
    output logic              rob_src0_filled,
    output logic [LOG_S-1:0]  rob_src0_slot,
    input  logic [REG_AW-1:0] rob_src1_reg,
    output logic              rob_src1_pend,
    output logic              rob_src1_filled,
    output logic [LOG_S-1:0]  rob_src1_slot,
    output logic              rob_empty
);

    localparam logic [LOG_S:0] CNT_FULL = (LOG_S+1)'(SLOTS);

    rob_entry_t       entry_q [SLOTS];
    rob_entry_t       entry_d [SLOTS];
    logic [LOG_S-1:0] head_q, head_d;
    logic [LOG_S-1:0] tail_q, tail_d;
    logic [LOG_S:0]   count_q, count_d;

    logic             alloc_fire;
    logic             fill_ok;
    logic [SLOTS-1:0] match0, match1;
    logic             found0, found1;
    logic [LOG_S-1:0] slot0, slot1;

    assign rob_alloc_req_rdy   = (count_q != CNT_FULL);
    assign alloc_fire          = rob_alloc_req_val && rob_alloc_req_rdy;
    assign rob_alloc_resp_slot = tail_q;
    assign rob_empty           = (count_q == '0);

    assign rob_commit_val   = entry_q[head_q].valid && !entry_q[head_q].pending;
    assign rob_commit_wen   = rob_commit_val && entry_q[head_q].wen;
    assign rob_commit_slot  = head_q;
    assign rob_commit_waddr = entry_q[head_q].waddr;

    assign fill_ok = entry_q[rob_fill_slot].valid
                  && entry_q[rob_fill_slot].pending;

    always_comb begin
        entry_d = entry_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (rob_commit_val) begin
            entry_d[head_q].valid = 1'b0;
            head_d = head_q + LOG_S'(1);
        end
        if (alloc_fire) begin
            entry_d[tail_q].valid   = 1'b1;
            entry_d[tail_q].pending = 1'b1;
            // r0 is never a real destination.
            entry_d[tail_q].wen     = rob_alloc_req_wen
                                   && (rob_alloc_req_waddr != '0);
            entry_d[tail_q].waddr   = rob_alloc_req_waddr;
            tail_d = tail_q + LOG_S'(1);
        end
        if (rob_fill_val && fill_ok) begin
            entry_d[rob_fill_slot].pending = 1'b0;
        end
        count_d = count_q
                + {{LOG_S{1'b0}}, alloc_fire}
                - {{LOG_S{1'b0}}, rob_commit_val};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_q <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q <= entry_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && rob_fill_val) begin
            assert (fill_ok);
        end
    end

    always_comb begin
        match0 = '0;
        match1 = '0;
        for (int i = 0; i < SLOTS; i++) begin
            match0[i] = entry_q[i].valid && entry_q[i].wen
                     && (entry_q[i].waddr == rob_src0_reg)
                     && (rob_src0_reg != '0);
            match1[i] = entry_q[i].valid && entry_q[i].wen
                     && (entry_q[i].waddr == rob_src1_reg)
                     && (rob_src1_reg != '0);
        end
    end

    riscv_core_rob_youngest_match #(.SLOTS(SLOTS), .LOG_S(LOG_S)) u_match0 (
        .match (match0),
        .tail  (tail_q),
        .found (found0),
        .slot  (slot0)
    );

    riscv_core_rob_youngest_match #(.SLOTS(SLOTS), .LOG_S(LOG_S)) u_match1 (
        .match (match1),
        .tail  (tail_q),
        .found (found1),
        .slot  (slot1)
    );

    assign rob_src0_pend   = found0;
    assign rob_src0_filled = found0 && !entry_q[slot0].pending;
    assign rob_src0_slot   = slot0;
    assign rob_src1_pend   = found1;
    assign rob_src1_filled = found1 && !entry_q[slot1].pending;
    assign rob_src1_slot   = slot1;

endmodule

// File: tb/tb_riscv_core_rob_ctrl.sv
// Directed bench for the ROB control block; retirements are
// checked against a program-order scoreboard filled at allocation.
module tb_riscv_core_rob_ctrl;
    import riscv_core_rob_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_val = 1'b0;
    logic       alloc_rdy;
    logic       alloc_wen = 1'b0;
    logic [4:0] alloc_waddr = '0;
    logic [3:0] resp_slot;
    logic       fill_val = 1'b0;
    logic [3:0] fill_slot = '0;
    logic       commit_val, commit_wen;
    logic [3:0] commit_slot;
    logic [4:0] commit_waddr;
    logic [4:0] src0_reg = '0, src1_reg = '0;
    logic       src0_pend, src0_filled, src1_pend, src1_filled;
    logic [3:0] src0_slot, src1_slot;
    logic       empty;

    typedef struct {
        logic [3:0] slot;
        logic       wen;
        logic [4:0] waddr;
    } exp_t;

    exp_t       exp_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] exp_tail = '0;

    riscv_core_rob_ctrl dut (
        .clk                 (clk),
        .reset               (reset),
        .rob_alloc_req_val   (alloc_val),
        .rob_alloc_req_rdy   (alloc_rdy),
        .rob_alloc_req_wen   (alloc_wen),
        .rob_alloc_req_waddr (alloc_waddr),
        .rob_alloc_resp_slot (resp_slot),
        .rob_fill_val        (fill_val),
        .rob_fill_slot       (fill_slot),
        .rob_commit_val      (commit_val),
        .rob_commit_wen      (commit_wen),
        .rob_commit_slot     (commit_slot),
        .rob_commit_waddr    (commit_waddr),
        .rob_src0_reg        (src0_reg),
        .rob_src0_pend       (src0_pend),
        .rob_src0_filled     (src0_filled),
        .rob_src0_slot       (src0_slot),
        .rob_src1_reg        (src1_reg),
        .rob_src1_pend       (src1_pend),
        .rob_src1_filled     (src1_filled),
        .rob_src1_slot       (src1_slot),
        .rob_empty           (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", nm, act, req);
        end
    endtask

    // Monitor: every retirement must match the oldest allocation.
    always @(negedge clk) begin
        if (!reset && commit_val) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL commit_unexpected: got slot %0d required none",
                         commit_slot);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("commit_slot", commit_slot, e.slot);
                chk("commit_wen", commit_wen, e.wen);
                chk("commit_waddr", commit_waddr, e.waddr);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_val = 1'b0;
        fill_val  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_exp(input logic w, input logic [4:0] a);
        exp_t e;
        e.slot  = exp_tail;
        e.wen   = w && (a != 5'd0);
        e.waddr = a;
        exp_q.push_back(e);
        exp_tail = exp_tail + 4'd1;
    endtask

    task automatic alloc(input logic w, input logic [4:0] a);
        alloc_val   = 1'b1;
        alloc_wen   = w;
        alloc_waddr = a;
        #1;
        chk("alloc_rdy", alloc_rdy, 1);
        chk("alloc_slot", resp_slot, exp_tail);
        push_exp(w, a);
        tick();
    endtask

    task automatic fill(input logic [3:0] s);
        fill_val  = 1'b1;
        fill_slot = s;
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rdy", alloc_rdy, 1);
        chk("rst_resp_slot", resp_slot, 0);
        chk("rst_commit_val", commit_val, 0);
        chk("rst_commit_wen", commit_wen, 0);
        chk("rst_empty", empty, 1);
        chk("rst_src0_pend", src0_pend, 0);
        chk("rst_src1_pend", src1_pend, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Single alloc, query, fill, commit
        alloc(1'b1, 5'd5);
        src0_reg = 5'd5;
        #1;
        chk("q1_pend", src0_pend, 1);
        chk("q1_filled", src0_filled, 0);
        chk("q1_slot", src0_slot, 0);
        chk("q1_empty", empty, 0);
        chk("q1_commit_val", commit_val, 0);
        fill_val  = 1'b1;
        fill_slot = 4'd0;
        #1;
        chk("q1_same_cycle_fill", src0_filled, 0);
        tick();
        chk("q1_filled_after", src0_filled, 1);
        chk("q1_pend_committing", src0_pend, 1);
        chk("q1_commit_now", commit_val, 1);
        tick();
        chk("q1_empty_after", empty, 1);
        chk("q1_pend_after", src0_pend, 0);

        // Fill up all 16 slots (head=tail=1), first one writes r0
        for (int i = 0; i < 16; i++) alloc(1'b1, 5'(i));
        alloc_val = 1'b1;
        #1;
        chk("full_rdy", alloc_rdy, 0);
        chk("full_tail", resp_slot, 1);
        chk("full_empty", empty, 0);
        tick();
        fill(4'd1);
        chk("full_commit_val", commit_val, 1);
        chk("full_rdy_no_credit", alloc_rdy, 0);
        tick();
        chk("full_rdy_after", alloc_rdy, 1);
        for (int k = 0; k < 15; k++) fill(4'(16 - k));
        idle(18);
        chk("full_drain_empty", empty, 1);

        // Youngest producer selection (head=tail=1)
        alloc(1'b1, 5'd3);
        alloc(1'b1, 5'd7);
        alloc(1'b1, 5'd3);
        src0_reg = 5'd3;
        src1_reg = 5'd9;
        alloc_val   = 1'b1;
        alloc_wen   = 1'b1;
        alloc_waddr = 5'd9;
        #1;
        chk("byp_young_slot", src0_slot, 3);
        chk("byp_young_pend", src0_pend, 1);
        chk("byp_same_alloc", src1_pend, 0);
        chk("byp_alloc_slot", resp_slot, 4);
        push_exp(1'b1, 5'd9);
        tick();
        chk("byp_new_pend", src1_pend, 1);
        chk("byp_new_slot", src1_slot, 4);
        src1_reg = 5'd7;
        #1;
        chk("byp_r7_slot", src1_slot, 2);
        fill(4'd3);
        idle(2);
        chk("byp_blocked", commit_val, 0);
        chk("byp_b_filled", src0_filled, 1);
        chk("byp_b_slot", src0_slot, 3);
        fill(4'd4);
        fill(4'd2);
        fill(4'd1);
        idle(8);
        chk("byp_drain_empty", empty, 1);

        // Wrap around the end of the buffer (head=tail=5 -> 14)
        for (int i = 0; i < 9; i++) alloc(1'b0, 5'd0);
        for (int s = 5; s < 14; s++) fill(4'(s));
        idle(12);
        chk("wrap_pre_empty", empty, 1);
        chk("wrap_pre_tail", resp_slot, 14);
        alloc(1'b1, 5'd10);
        alloc(1'b1, 5'd11);
        alloc(1'b1, 5'd12);
        alloc(1'b1, 5'd13);
        chk("wrap_tail", resp_slot, 2);
        fill(4'd1);
        fill(4'd0);
        fill(4'd15);
        idle(2);
        chk("wrap_blocked", commit_val, 0);
        fill(4'd14);
        idle(8);
        chk("wrap_drain_empty", empty, 1);

        // Asynchronous reset with entries in flight (head=tail=2)
        for (int i = 1; i <= 5; i++) alloc(1'b1, 5'(i));
        fill(4'd3);
        fill(4'd4);
        src0_reg = 5'd3;
        #1;
        chk("mid_pend", src0_pend, 1);
        reset = 1'b1;
        #1;
        chk("arst_empty", empty, 1);
        chk("arst_rdy", alloc_rdy, 1);
        chk("arst_commit_val", commit_val, 0);
        chk("arst_resp_slot", resp_slot, 0);
        chk("arst_src0_pend", src0_pend, 0);
        exp_q.delete();
        exp_tail = '0;
        tick();
        reset = 1'b0;
        tick();
        alloc(1'b1, 5'd6);
        fill(4'd0);
        idle(4);
        chk("post_rst_empty", empty, 1);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
